// File: rtl/seq_conv_engine_pkg.sv
// Shared types and width helpers for the sequential convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        OUT   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Wide enough that TAPS full-precision products can never overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

    function automatic int idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/seq_conv_engine_if.sv
// Sample/result stream and coefficient-write bus of the convolution engine.
interface seq_conv_engine_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4
);
    import conv_pkg::*;

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int IDX_W = idx_width(TAPS);

    logic                     coef_we;
    logic [IDX_W-1:0]         coef_idx;
    logic signed [COEF_W-1:0] coef_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [ACC_W-1:0]  m_data;
    logic                     m_last;

    modport master (
        output coef_we, coef_idx, coef_data, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  coef_we, coef_idx, coef_data, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/seq_conv_engine_mac.sv
// Registered signed multiply-accumulate: clear has priority over enable.
module conv_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    assign prod = (A_W+B_W)'(a_i) * (A_W+B_W)'(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clear_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/seq_conv_engine.sv
// Sequential full-length convolution: one shared MAC, TAPS cycles per result, zero-fed tail after s_last.
module seq_conv_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_conv_engine_if.slave bus
);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int IDX_W = idx_width(TAPS);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(TAPS - 1);

    state_t                   state_q, state_d;
    logic                     ready_en_q;
    logic signed [DATA_W-1:0] line_q [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic [IDX_W-1:0]         k_q, tail_q;
    logic                     last_seen_q;
    logic signed [ACC_W-1:0]  m_data_q, mac_acc;
    logic                     m_last_q;

    logic s_ready_w, out_w, accept, out_hs, final_res, coef_wr;
    logic shift_en, clear_line, mac_clear, mac_en;
    logic signed [DATA_W-1:0] shift_in;

    assign s_ready_w = ready_en_q & (state_q == IDLE);
    assign out_w     = (state_q == OUT);
    assign accept    = bus.s_valid & s_ready_w;
    assign out_hs    = out_w & bus.m_ready;
    assign final_res = last_seen_q & (tail_q == '0);
    assign coef_wr   = bus.coef_we & (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = MAC;
            MAC:   if (k_q == LAST_K) state_d = OUT;
            OUT: begin
                if (out_hs)
                    state_d = (last_seen_q && tail_q != '0) ? FLUSH : IDLE;
            end
            FLUSH: state_d = MAC;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready = s_ready_w;
        bus.m_valid = out_w;
        bus.m_data  = out_w ? mac_acc : m_data_q;
        bus.m_last  = out_w ? final_res : m_last_q;
        mac_clear   = accept | (state_q == FLUSH);
        mac_en      = (state_q == MAC);
        shift_en    = accept | (state_q == FLUSH);
        shift_in    = (state_q == FLUSH) ? '0 : bus.s_data;
        clear_line  = out_hs & final_res;
    end

    // Counters, frame bookkeeping and the output hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            k_q         <= '0;
            tail_q      <= '0;
            last_seen_q <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (mac_clear)
                k_q <= '0;
            else if (mac_en)
                k_q <= k_q + IDX_W'(1);
            if (accept) begin
                last_seen_q <= bus.s_last;
                tail_q      <= bus.s_last ? LAST_K : '0;
            end else if (state_q == FLUSH) begin
                tail_q <= tail_q - IDX_W'(1);
            end else if (clear_line) begin
                last_seen_q <= 1'b0;
            end
            if (out_w) begin
                m_data_q <= mac_acc;
                m_last_q <= final_res;
            end
        end
    end

    // Delay line and coefficient file; line is wiped after the final result of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (clear_line) begin
                for (int i = 0; i < TAPS; i++)
                    line_q[i] <= '0;
            end else if (shift_en) begin
                for (int i = TAPS - 1; i > 0; i--)
                    line_q[i] <= line_q[i-1];
                line_q[0] <= shift_in;
            end
            for (int i = 0; i < TAPS; i++) begin
                if (coef_wr && bus.coef_idx == IDX_W'(i))
                    coef_q[i] <= bus.coef_data;
            end
        end
    end

    conv_mac #(
        .A_W   (COEF_W),
        .B_W   (DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .a_i     (coef_q[k_q]),
        .b_i     (line_q[k_q]),
        .acc_o   (mac_acc)
    );

endmodule

// File: tb/tb_seq_conv_engine.sv
// Randomised self-checking bench for seq_conv_engine against a direct convolution model.
module tb_seq_conv_engine;
    import conv_pkg::*;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;

    typedef struct {
        longint d;
        bit     l;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_conv_engine_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus();

    seq_conv_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     vec_cnt = 0;
    int     err_cnt = 0;
    res_t   got_q[$];
    int     hm[TAPS];
    longint cyc = 0;
    longint acc_cyc = 0;
    longint lat_cyc = 0;
    bit     lat_pending = 0;
    bit     rand_bp = 0;
    bit     stall_arm = 0;
    bit     stall_watch = 0;
    int     stall_left = 0;
    int     stall_idx = 0;
    longint stall_exp = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor: records accepted results, checks outputs while stalled.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid) begin
            if (lat_pending) begin
                lat_cyc = cyc;
                lat_pending = 0;
            end
            if (bus.m_ready)
                got_q.push_back('{longint'(bus.m_data), bus.m_last});
            else if (stall_watch) begin
                chk("stall_m_data", bus.m_data, stall_exp);
                chk("stall_s_ready", longint'(bus.s_ready), 0);
            end
        end
    end

    // Downstream ready: scripted stall, random backpressure, or always ready.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                bus.m_ready = 1'b0;
                stall_left--;
            end else if (stall_arm && bus.m_valid && got_q.size() == stall_idx) begin
                stall_arm = 0;
                stall_left = 4;
                bus.m_ready = 1'b0;
            end else begin
                bus.m_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_coef(input int idx, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_idx  = 2'(idx);
        bus.coef_data = COEF_W'(val);
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        hm[idx] = val;
    endtask

    task automatic set_h(input int h0, input int h1, input int h2, input int h3);
        write_coef(0, h0);
        write_coef(1, h1);
        write_coef(2, h2);
        write_coef(3, h3);
    endtask

    // inj: 0 none, 1 write h[0] while busy (must be ignored), 2 write h[0] with first sample (must apply).
    task automatic run_frame(input string name, input int xs[$], input int inj, input int inj_val);
        res_t exp_q[$];
        int   n;
        int   waitc;
        n = xs.size();
        got_q.delete();
        if (inj == 2) hm[0] = inj_val;
        for (int i = 0; i < n + TAPS - 1; i++) begin
            longint y = 0;
            for (int k = 0; k < TAPS; k++)
                if (i - k >= 0 && i - k < n)
                    y += longint'(hm[k]) * longint'(xs[i-k]);
            exp_q.push_back('{y, (i == n + TAPS - 2)});
        end
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DATA_W'(xs[i]);
            bus.s_last  = (i == n - 1);
            if (inj == 2 && i == 0) begin
                bus.coef_we   = 1'b1;
                bus.coef_idx  = '0;
                bus.coef_data = COEF_W'(inj_val);
            end
            waitc = 0;
            do begin
                @(negedge clk);
                waitc++;
            end while (!bus.s_ready && waitc < 200);
            if (!bus.s_ready) begin
                chk({name, "_accept_timeout"}, 0, 1);
                bus.s_valid = 1'b0;
                bus.coef_we = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            bus.coef_we = 1'b0;
            if (i == 0) begin
                acc_cyc = cyc;
                chk({name, "_s_ready_busy"}, longint'(bus.s_ready), 0);
            end
            if (inj == 1 && i == 0) begin
                bus.coef_we   = 1'b1;
                bus.coef_idx  = '0;
                bus.coef_data = COEF_W'(inj_val);
                @(posedge clk); #1;
                bus.coef_we = 1'b0;
            end
        end
        waitc = 0;
        while (got_q.size() < exp_q.size() && waitc < 1000) begin
            @(posedge clk); #1;
            waitc++;
        end
        repeat (2 * TAPS + 4) begin
            @(posedge clk); #1;
        end
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_y%0d", name, i), got_q[i].d, exp_q[i].d);
            chk($sformatf("%s_last%0d", name, i), longint'(got_q[i].l), longint'(exp_q[i].l));
        end
    endtask

    initial begin
        int xs[$];
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        bus.coef_we = 1'b0;
        bus.coef_idx = '0;
        bus.coef_data = '0;
        for (int k = 0; k < TAPS; k++) hm[k] = 0;

        // Reset state
        #12;
        chk("rst_s_ready", longint'(bus.s_ready), 0);
        chk("rst_m_valid", longint'(bus.m_valid), 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", longint'(bus.m_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_s_ready", longint'(bus.s_ready), 1);

        // Ramp frame, also measuring first-result latency
        set_h(1, 2, 3, 4);
        xs.delete();
        for (int i = 0; i < 4; i++) xs.push_back(1);
        lat_pending = 1;
        run_frame("t1", xs, 0, 0);
        chk("t1_latency", lat_cyc - acc_cyc, TAPS);

        // Extreme values, no wrap
        set_h(-1, 0, 0, 0);
        xs.delete(); xs.push_back(-128);
        run_frame("t2a", xs, 0, 0);
        set_h(-128, -128, -128, -128);
        run_frame("t2b", xs, 0, 0);

        // Output held under a 5-cycle stall on the second result
        set_h(1, 2, 3, 4);
        xs.delete();
        for (int i = 0; i < 4; i++) xs.push_back(1);
        stall_arm = 1; stall_idx = 1; stall_exp = 3; stall_watch = 1;
        run_frame("t3", xs, 0, 0);
        stall_watch = 0;
        chk("t3_stall_fired", longint'(stall_arm), 0);

        // Coefficient write while busy is ignored; in idle it applies
        run_frame("t4a", xs, 1, 5);
        write_coef(0, 5);
        run_frame("t4b", xs, 0, 0);
        run_frame("t4c", xs, 2, -7);

        // Reset in the middle of a MAC
        set_h(1, 2, 3, 4);
        bus.s_valid = 1'b1; bus.s_data = 8'sd7; bus.s_last = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", longint'(bus.m_valid), 0);
        chk("midrst_s_ready", longint'(bus.s_ready), 0);
        chk("midrst_m_data", bus.m_data, 0);
        for (int k = 0; k < TAPS; k++) hm[k] = 0;
        @(posedge clk); #1;
        chk("midrst_s_ready_held", longint'(bus.s_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rel_s_ready", longint'(bus.s_ready), 1);
        xs.delete(); xs.push_back(7);
        run_frame("t5", xs, 0, 0);

        // Back-to-back independent frames
        set_h(1, 1, 1, 1);
        xs.delete(); xs.push_back(2);
        run_frame("t6a", xs, 0, 0);
        xs.delete(); xs.push_back(3);
        run_frame("t6b", xs, 0, 0);

        // Random frames with random backpressure
        rand_bp = 1;
        for (int f = 0; f < 16; f++) begin
            int len;
            set_h(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            len = int'($urandom_range(1, 6));
            xs.delete();
            for (int i = 0; i < len; i++) xs.push_back(int'($urandom_range(0, 255)) - 128);
            run_frame($sformatf("rnd%0d", f), xs, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 255)) - 128);
        end
        rand_bp = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
